// File: rtl/vga_timing_gen.sv
// Raster timing for the VGA path: pixel position, visible flag, line/frame pulses
// and sync outputs delayed to line up with the downstream registered RGB.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic       HS_ON     = (HS_POL != 0);
    localparam logic       VS_ON     = (VS_POL != 0);
    localparam logic [1:0] SYNC_IDLE = {~HS_ON, ~VS_ON};

    logic       running;
    logic       h_wrap, v_wrap;
    logic       hs_on, vs_on;
    logic [9:0] nx, ny;

    // [0] is the undelayed registered decode, [SYNC_DELAY] drives the pins; bit1 = hs, bit0 = vs
    logic [SYNC_DELAY:0][1:0] sync_pipe;

    // Everything is decoded from the next position so the registered flags
    // describe the same pixel as the registered DrawX/DrawY.
    always_comb begin
        h_wrap = running && (DrawX == H_LAST);
        v_wrap = h_wrap && (DrawY == V_LAST);
        nx     = DrawX + 10'd1;
        ny     = DrawY;
        if (!running) begin
            nx = '0;
            ny = '0;
        end else if (h_wrap) begin
            nx = '0;
            ny = v_wrap ? '0 : DrawY + 10'd1;
        end
        hs_on = (nx >= HS_BEG) && (nx <= HS_END);
        vs_on = (ny >= VS_BEG) && (ny <= VS_END);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            running     <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
            sync_pipe   <= {(SYNC_DELAY + 1){SYNC_IDLE}};
        end else begin
            running     <= 1'b1;
            DrawX       <= nx;
            DrawY       <= ny;
            blank       <= (nx < H_VIS) && (ny < V_VIS);
            line_start  <= (nx == '0);
            frame_start <= (nx == '0) && (ny == '0);
            if (v_wrap)
                frame_count <= frame_count + 8'd1;
            sync_pipe[0] <= {hs_on ? HS_ON : ~HS_ON, vs_on ? VS_ON : ~VS_ON};
            for (int i = 1; i <= SYNC_DELAY; i++)
                sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    assign hs = sync_pipe[SYNC_DELAY][1];
    assign vs = sync_pipe[SYNC_DELAY][0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, sync-delay / polarity
// variants, and a shrunken raster for frame-level and wrap behaviour.
module tb_vga_timing_gen;
    logic vga_clk;
    logic reset_n;

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // d_: defaults, z_: SYNC_DELAY 0, t_: SYNC_DELAY 3, p_: HS_POL 1, s_: small raster
    logic [9:0] d_x, d_y, z_x, z_y, t_x, t_y, p_x, p_y, s_x, s_y;
    logic       d_blank, d_hs, d_vs, d_ls, d_fs;
    logic       z_blank, z_hs, z_vs, z_ls, z_fs;
    logic       t_blank, t_hs, t_vs, t_ls, t_fs;
    logic       p_blank, p_hs, p_vs, p_ls, p_fs;
    logic       s_blank, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] d_fc, z_fc, t_fc, p_fc, s_fc;

    vga_timing_gen dut_d (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
        .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc));

    vga_timing_gen #(.SYNC_DELAY(0)) dut_z (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(z_x), .DrawY(z_y), .blank(z_blank),
        .hs(z_hs), .vs(z_vs), .line_start(z_ls), .frame_start(z_fs), .frame_count(z_fc));

    vga_timing_gen #(.SYNC_DELAY(3)) dut_t (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(t_x), .DrawY(t_y), .blank(t_blank),
        .hs(t_hs), .vs(t_vs), .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc));

    vga_timing_gen #(.HS_POL(1)) dut_p (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(p_x), .DrawY(p_y), .blank(p_blank),
        .hs(p_hs), .vs(p_vs), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc));

    // 16 x 8 raster: hs undelayed on x 10..12, vs undelayed on y 5, 128 cycles per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) dut_s (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        int n;
        int fall_d, fall_z, fall_t, rise_p, last_d;
        int wid_d, wid_z, wid_t, wid_p;
        int blank_err, pos_err, vs_err;
        int px, py, ex, ey, max_x, max_y;
        int s_pos_err, s_blank_err, s_sync_err, s_pulse_err, s_fc_err, s_per_err, last_fs;
        logic [7:0] fc_exp;
        logic exp_hs, exp_vs;

        // ---------------- reset ----------------
        reset_n = 1'b0;
        repeat (5) tick();
        chk("rst_x", d_x, 0);
        chk("rst_y", d_y, 0);
        chk("rst_blank", d_blank, 0);
        chk("rst_ls", d_ls, 0);
        chk("rst_fs", d_fs, 0);
        chk("rst_fc", d_fc, 0);
        chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1);
        chk("rst_hs_pol1", p_hs, 0);

        reset_n = 1'b1;
        tick();
        chk("e1_x", d_x, 0);
        chk("e1_y", d_y, 0);
        chk("e1_blank", d_blank, 1);
        chk("e1_ls", d_ls, 1);
        chk("e1_fs", d_fs, 1);
        chk("e1_fc", d_fc, 0);
        tick();
        chk("e2_x", d_x, 1);
        chk("e2_blank", d_blank, 1);
        chk("e2_ls", d_ls, 0);
        chk("e2_fs", d_fs, 0);

        // ---------------- one full line, default timing ----------------
        fall_d = -1; fall_z = -1; fall_t = -1; rise_p = -1; last_d = -1;
        wid_d = 0; wid_z = 0; wid_t = 0; wid_p = 0;
        blank_err = 0; pos_err = 0; vs_err = 0; max_x = 0;
        n = 2;
        while (n < 1000) begin
            tick();
            if (d_x == 10'd0) break;
            if (d_x != 10'(n)) pos_err++;
            if (int'(d_x) > max_x) max_x = int'(d_x);
            if (d_blank !== (d_x < 10'd640)) blank_err++;
            if (d_vs !== 1'b1) vs_err++;
            if (d_hs === 1'b0) begin
                if (fall_d < 0) fall_d = int'(d_x);
                last_d = int'(d_x);
                wid_d++;
            end
            if (z_hs === 1'b0) begin if (fall_z < 0) fall_z = int'(d_x); wid_z++; end
            if (t_hs === 1'b0) begin if (fall_t < 0) fall_t = int'(d_x); wid_t++; end
            if (p_hs === 1'b1) begin if (rise_p < 0) rise_p = int'(d_x); wid_p++; end
            n++;
        end
        chk("line_len", n, 800);
        chk("line_pos", pos_err, 0);
        chk("line_maxx", max_x, 799);
        chk("line_blank", blank_err, 0);
        chk("line_vs_idle", vs_err, 0);
        chk("hs_d1_fall", fall_d, 657);
        chk("hs_d1_last", last_d, 752);
        chk("hs_d1_width", wid_d, 96);
        chk("hs_d0_fall", fall_z, 656);
        chk("hs_d0_width", wid_z, 96);
        chk("hs_d3_fall", fall_t, 659);
        chk("hs_d3_width", wid_t, 96);
        chk("hs_pol1_rise", rise_p, 657);
        chk("hs_pol1_width", wid_p, 96);
        chk("row_x", d_x, 0);
        chk("row_y", d_y, 1);
        chk("row_ls", d_ls, 1);
        chk("row_fs", d_fs, 0);

        // ---------------- mid-line reset inside the hs pulse ----------------
        n = 0;
        while (d_x != 10'd700 && n < 1000) begin
            tick();
            n++;
        end
        chk("mid_reach_x", d_x, 700);
        chk("mid_hs_active", d_hs, 0);
        chk("mid_hs_pol1_active", p_hs, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_x", d_x, 0);
        chk("mid_y", d_y, 0);
        chk("mid_blank", d_blank, 0);
        chk("mid_ls", d_ls, 0);
        chk("mid_fs", d_fs, 0);
        chk("mid_hs", d_hs, 1);
        chk("mid_vs", d_vs, 1);
        chk("mid_hs_pol1", p_hs, 0);
        chk("mid_hs_d3", t_hs, 1);
        chk("mid_small_fc", s_fc, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("re1_x", d_x, 0);
        chk("re1_y", d_y, 0);
        chk("re1_blank", d_blank, 1);
        chk("re1_fs", d_fs, 1);
        chk("re1_fc", d_fc, 0);
        chk("re1_hs_d3", t_hs, 1);
        chk("re1_small_fs", s_fs, 1);
        tick();
        chk("re2_hs_d3", t_hs, 1);
        chk("re2_x", d_x, 1);

        // ---------------- small raster: 256 frames from its edge 1 ----------------
        // The small DUT is one cycle past its edge 1 here; replay that cycle in the model.
        px = 1; py = 0; fc_exp = 8'd0; last_fs = 0;
        max_x = 0; max_y = 0;
        s_pos_err = 0; s_blank_err = 0; s_sync_err = 0; s_pulse_err = 0; s_fc_err = 0; s_per_err = 0;
        for (int cyc = 2; cyc <= 256 * 128; cyc++) begin
            tick();
            ex = (px == 15) ? 0 : px + 1;
            ey = (px == 15) ? ((py == 7) ? 0 : py + 1) : py;
            exp_hs = !(px >= 10 && px <= 12);
            exp_vs = !(py == 5);
            if (ex == 0 && ey == 0) begin
                fc_exp = fc_exp + 8'd1;
                if (cyc - last_fs != 128) s_per_err++;
                last_fs = cyc;
                if (fc_exp == 8'd0) begin
                    chk("fc_wrap_value", s_fc, 0);
                    chk("fc_wrap_fs", s_fs, 1);
                end
            end
            if (s_x != 10'(ex) || s_y != 10'(ey)) s_pos_err++;
            if (int'(s_x) > max_x) max_x = int'(s_x);
            if (int'(s_y) > max_y) max_y = int'(s_y);
            if (s_blank !== (ex < 8 && ey < 4)) s_blank_err++;
            if (s_hs !== exp_hs || s_vs !== exp_vs) s_sync_err++;
            if (s_ls !== (ex == 0) || s_fs !== (ex == 0 && ey == 0)) s_pulse_err++;
            if (s_fc !== fc_exp) s_fc_err++;
            px = ex;
            py = ey;
        end
        chk("s_pos", s_pos_err, 0);
        chk("s_maxx", max_x, 15);
        chk("s_maxy", max_y, 7);
        chk("s_blank", s_blank_err, 0);
        chk("s_sync", s_sync_err, 0);
        chk("s_pulses", s_pulse_err, 0);
        chk("s_fc", s_fc_err, 0);
        chk("s_frame_period", s_per_err, 0);
        chk("s_last_fs_cycle", last_fs, 256 * 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule
